// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection, variable-latency imem handshake,
// IF/ID pipeline register with redirect and stall handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] buf_instr;
  logic        pend;
  logic [31:0] pend_tgt;

  logic [31:0] pc4;
  logic        redir_in;
  logic [31:0] target;

  // RESET_PC documents the PC register's reset value; this block never drives it.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  assign pc4       = pc + 32'd4;
  assign redir_in  = branch_taken | jump;
  // EX is older than ID, so a taken branch beats a simultaneous jump.
  assign target    = branch_taken ? branch_target : {pc4[31:28], jump_index, 2'b00};
  assign imem_addr = pc;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    imem_req = (state == REQ);
    pc_next  = pc;
    case (state)
      REQ: begin
        if (redir_in && imem_ready)    pc_next = target;
        else if (redir_in)             pc_next = pc;
        else if (pend && imem_ready)   pc_next = pend_tgt;
        else if (imem_ready && !stall) pc_next = pc4;
      end
      HOLD: begin
        if (redir_in)    pc_next = target;
        else if (!stall) pc_next = pc4;
      end
      default: pc_next = pc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the async reset
  // clears every register including the single-word instruction buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      buf_instr   <= 32'd0;
      pend        <= 1'b0;
      pend_tgt    <= 32'd0;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redir_in && imem_ready) begin
            pend        <= 1'b0;
            if_id_valid <= 1'b0;
          end else if (redir_in) begin
            // A newer redirect overwrites any older pending target.
            pend        <= 1'b1;
            pend_tgt    <= target;
            if_id_valid <= 1'b0;
          end else if (pend && imem_ready) begin
            pend        <= 1'b0;
            if_id_valid <= 1'b0;
          end else if (imem_ready && !stall) begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
          end else if (imem_ready) begin
            buf_instr <= imem_rdata;
            state     <= HOLD;
          end else if (!stall) begin
            if_id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redir_in) begin
            if_id_valid <= 1'b0;
            state       <= REQ;
          end else if (!stall) begin
            if_id_instr <= buf_instr;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the PC register and an imem returning
// 32'h2000_0000 | addr, with hand-computed expectations at each step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int tests  = 0;
  int failed = 0;

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  // PC register: loads pc_next every cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'd0;
    else       pc <= pc_next;
  end

  assign imem_rdata = 32'h2000_0000 | imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] p4, input logic v);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc4,   p4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  // Redirect from REQ with a ready memory: pc becomes tgt next cycle.
  task automatic go_to(input logic [31:0] tgt);
    branch_taken = 1'b1; branch_target = tgt; imem_ready = 1'b1; stall = 1'b0;
    #1;
    check("goto.pc_next", pc_next, tgt);
    step();
    branch_taken = 1'b0;
    check("goto.pc", pc, tgt);
    check("goto.valid", {31'd0, if_id_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_index = 26'd0;
    step(); step();
    check_ifid("rst", 32'd0, 32'd0, 1'b0);
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.pc_next", pc_next, 32'd0);

    // IDLE cycle, then streaming with zero-wait memory.
    reset = 1'b0;
    #1;
    check("idle.req", {31'd0, imem_req}, 32'd0);
    check("idle.pc_next", pc_next, 32'd0);
    step();
    check("req0.req", {31'd0, imem_req}, 32'd1);
    check("req0.pc_next", pc_next, 32'd4);
    step();
    check_ifid("s0", 32'h2000_0000, 32'd4, 1'b1);
    check("s0.pc_next", pc_next, 32'd8);
    step();
    check_ifid("s1", 32'h2000_0004, 32'd8, 1'b1);
    step();
    check_ifid("s2", 32'h2000_0008, 32'd12, 1'b1);

    // Two wait states at 0x40.
    go_to(32'h40);
    imem_ready = 1'b0;
    #1;
    check("w0.req", {31'd0, imem_req}, 32'd1);
    check("w0.pc_next", pc_next, 32'h40);
    step();
    check("w0.valid", {31'd0, if_id_valid}, 32'd0);
    check("w1.pc_next", pc_next, 32'h40);
    check("w1.addr", imem_addr, 32'h40);
    step();
    check("w1.valid", {31'd0, if_id_valid}, 32'd0);
    imem_ready = 1'b1;
    #1;
    check("w2.pc_next", pc_next, 32'h44);
    step();
    check_ifid("w2", 32'h2000_0040, 32'h44, 1'b1);

    // Response under stall held for three cycles.
    stall = 1'b1;
    #1;
    check("st.pc_next", pc_next, 32'h44);
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold.req", {31'd0, imem_req}, 32'd0);
      check("hold.pc_next", pc_next, 32'h44);
      check_ifid("hold", 32'h2000_0040, 32'h44, 1'b1);
      if (i < 2) step();
    end
    stall = 1'b0;
    #1;
    check("rel.pc_next", pc_next, 32'h48);
    step();
    check_ifid("rel", 32'h2000_0044, 32'h48, 1'b1);
    check("rel.req", {31'd0, imem_req}, 32'd1);

    // Branch arriving while waiting at 0x80 becomes pending.
    go_to(32'h80);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    check("pend.pc_next", pc_next, 32'h80);
    step();
    branch_taken = 1'b0;
    #1;
    check("pend.hold_pc", pc_next, 32'h80);
    check("pend.valid", {31'd0, if_id_valid}, 32'd0);
    step();
    imem_ready = 1'b1;
    #1;
    check("pend.redir", pc_next, 32'h100);
    step();
    check("pend.drop", {31'd0, if_id_valid}, 32'd0);
    check("pend.addr", imem_addr, 32'h100);
    check("pend.next", pc_next, 32'h104);
    step();
    check_ifid("tgt", 32'h2000_0100, 32'h104, 1'b1);

    // Branch versus jump priority at 0xF000_0000.
    go_to(32'hF000_0000);
    imem_ready = 1'b1;
    jump = 1'b1; jump_index = 26'h0000010;
    branch_taken = 1'b1; branch_target = 32'h200;
    #1;
    check("bj.pc_next", pc_next, 32'h200);
    branch_taken = 1'b0;
    #1;
    check("j.pc_next", pc_next, 32'hF000_0040);
    step();
    jump = 1'b0;
    check("j.pc", pc, 32'hF000_0040);
    check("j.valid", {31'd0, if_id_valid}, 32'd0);

    // PC+4 wrap at the top of the address space.
    go_to(32'hFFFF_FFFC);
    #1;
    check("wrap.pc_next", pc_next, 32'd0);
    step();
    check_ifid("wrap", 32'hFFFF_FFFC, 32'd0, 1'b1);

    // Reset in the middle of HOLD.
    stall = 1'b1;
    step();
    check("h2.req", {31'd0, imem_req}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_ifid("mrst", 32'd0, 32'd0, 1'b0);
    check("mrst.req", {31'd0, imem_req}, 32'd0);
    check("mrst.pc_next", pc_next, pc);
    step();
    check_ifid("mrst2", 32'd0, 32'd0, 1'b0);
    reset = 1'b0; stall = 1'b0;
    #1;
    check("mrst.idle", {31'd0, imem_req}, 32'd0);
    step();
    check("mrst.req1", {31'd0, imem_req}, 32'd1);
    check("mrst.pc_next4", pc_next, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
